tagged_ooo_responder: RTL and testbench

- Response side of the ID-tagged reorder protocol. Accepts requests carrying a reorder-buffer ID, payload and per-request latency.
- Holds each request in a slot until its latency expires, then returns a response tagged with the same ID.
- Responses therefore leave out of request order. Block sits between the interconnect and a reorder buffer, as a variable-latency bank/peripheral responder or as a verification-grade responder model.

---
 rtl/tagged_resp_pkg.sv | 16 +
 rtl/tagged_ooo_responder_chk.sv | 54 +++++
 rtl/tagged_ooo_responder_slot.sv | 102 ++++++++++
 rtl/tagged_ooo_responder.sv | 165 ++++++++++++++++
 tb/tb_tagged_ooo_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tagged_resp_pkg.sv
// Shared types and helpers for the tagged out-of-order responder.
package tagged_resp_pkg;

    // Lifecycle of one outstanding-request slot.
    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } slot_state_e;

    // Width of a slot index. At least one bit, even for a single slot.
    function automatic int idx_width(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

// File: rtl/tagged_ooo_responder_chk.sv
// Simulation-only protocol checks for the tagged out-of-order responder.
module tagged_ooo_responder_chk #(
    parameter int DataWidth = 32,
    parameter int NumSlots  = 4,
    parameter int IdWidth   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic                          req_ready,
    input  logic [IdWidth-1:0]            req_id,
    input  logic [NumSlots-1:0]           occupied,
    input  logic [NumSlots*IdWidth-1:0]   ids_flat,
    input  logic                          resp_valid,
    input  logic                          resp_ready,
    input  logic [IdWidth-1:0]            resp_id,
    input  logic [DataWidth-1:0]          resp_data
);

    logic                 hold_r;
    logic [IdWidth-1:0]   held_id_r;
    logic [DataWidth-1:0] held_data_r;

    // Remember whether the previous cycle ended with a stalled response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r      <= 1'b0;
            held_id_r   <= '0;
            held_data_r <= '0;
        end else begin
            hold_r      <= resp_valid & ~resp_ready;
            held_id_r   <= resp_id;
            held_data_r <= resp_data;
        end
    end

    // Edge-sampled protocol assertions.
    always @(posedge clk) begin
        assert (NumSlots > 0) else $error("responder: NumSlots must be positive");
        if (!rst && hold_r) begin
            assert (resp_valid && resp_id == held_id_r && resp_data == held_data_r)
                else $error("responder: response changed while stalled");
        end
        if (!rst && req_valid && req_ready) begin
            for (int i = 0; i < NumSlots; i++) begin
                if (occupied[i]) begin
                    assert (ids_flat[i*IdWidth +: IdWidth] != req_id)
                        else $error("responder: request ID %0h already outstanding", req_id);
                end
            end
        end
    end

endmodule

// File: rtl/tagged_ooo_responder_slot.sv
// One outstanding-request slot: captures ID/payload on allocation, counts the
// requested latency down, and presents itself READY until its response is taken.
module responder_slot
    import tagged_resp_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4,
    parameter int LatWidth  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    input  logic [LatWidth-1:0]  alloc_lat,
    input  logic [IdWidth-1:0]   alloc_id,
    input  logic [DataWidth-1:0] alloc_data,
    input  logic                 rel,
    output slot_state_e          slot_state,
    output logic [IdWidth-1:0]   slot_id,
    output logic [DataWidth-1:0] slot_data
);

    slot_state_e          state_r;
    slot_state_e          state_s;
    logic [LatWidth-1:0]  cnt_r;
    logic [LatWidth-1:0]  cnt_s;
    logic [IdWidth-1:0]   id_r;
    logic [DataWidth-1:0] data_r;
    logic                 capture_s;

    // Capture only happens when the slot is genuinely free.
    assign capture_s = alloc & (state_r == FREE);

    // Next-state and countdown logic; the counter saturates at zero.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            FREE: begin
                if (alloc) begin
                    if (alloc_lat == '0) begin
                        state_s = READY;
                        cnt_s   = '0;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = alloc_lat;
                    end
                end else begin
                    state_s = FREE;
                end
            end
            WAIT: begin
                if (cnt_r <= LatWidth'(1)) begin
                    state_s = READY;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r - LatWidth'(1);
                end
            end
            READY: begin
                if (rel) begin
                    state_s = FREE;
                end else begin
                    state_s = READY;
                end
            end
            default: begin
                state_s = FREE;
                cnt_s   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FREE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request ID and payload held for the lifetime of the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r   <= '0;
            data_r <= '0;
        end else if (capture_s) begin
            id_r   <= alloc_id;
            data_r <= alloc_data;
        end else begin
            id_r   <= id_r;
            data_r <= data_r;
        end
    end

    assign slot_state = state_r;
    assign slot_id    = id_r;
    assign slot_data  = data_r;

endmodule

// File: rtl/tagged_ooo_responder.sv
// Variable-latency responder that returns ID-tagged responses out of order.
// Lowest-index free slot takes each request; READY slots are served
// round-robin, and a stalled response is locked until it is consumed.
module tagged_ooo_responder
    import tagged_resp_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumSlots  = 4,
    parameter int IdWidth   = 4,
    parameter int LatWidth  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [IdWidth-1:0]   req_id_i,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic [LatWidth-1:0]  req_lat_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [IdWidth-1:0]   resp_id_o,
    output logic [DataWidth-1:0] resp_data_o,
    output logic                 busy_o
);

    localparam int IdxW = idx_width(NumSlots);

    slot_state_e                 slot_state_s [NumSlots];
    logic [IdWidth-1:0]          slot_id_s    [NumSlots];
    logic [DataWidth-1:0]        slot_data_s  [NumSlots];
    logic [NumSlots-1:0]         free_s;
    logic [NumSlots-1:0]         ready_s;
    logic [NumSlots-1:0]         alloc_s;
    logic [NumSlots-1:0]         rel_s;
    logic [NumSlots*IdWidth-1:0] ids_flat_s;

    logic                        accept_s;
    logic                        handshake_s;
    logic                        pick_valid_s;
    logic [IdxW-1:0]             pick_idx_s;
    logic                        sel_valid_s;
    logic [IdxW-1:0]             sel_idx_s;
    logic [IdxW-1:0]             rr_next_s;

    logic [IdxW-1:0]             rr_r;
    logic                        lock_valid_r;
    logic [IdxW-1:0]             lock_idx_r;

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        responder_slot #(
            .DataWidth (DataWidth),
            .IdWidth   (IdWidth),
            .LatWidth  (LatWidth)
        ) u_slot (
            .clk        (clk_i),
            .rst        (rst_i),
            .alloc      (alloc_s[g]),
            .alloc_lat  (req_lat_i),
            .alloc_id   (req_id_i),
            .alloc_data (req_data_i),
            .rel        (rel_s[g]),
            .slot_state (slot_state_s[g]),
            .slot_id    (slot_id_s[g]),
            .slot_data  (slot_data_s[g])
        );
        assign free_s[g]                          = (slot_state_s[g] == FREE);
        assign ready_s[g]                         = (slot_state_s[g] == READY);
        assign ids_flat_s[g*IdWidth +: IdWidth]   = slot_id_s[g];
    end

    // Acceptance depends only on registered slot state, never on req_valid_i.
    assign req_ready_o = |free_s;
    assign busy_o      = ~(&free_s);
    assign accept_s    = req_valid_i & req_ready_o;

    // Priority encoder: the accepted request goes to the lowest free slot.
    always_comb begin
        logic taken;
        taken   = 1'b0;
        alloc_s = '0;
        for (int i = 0; i < NumSlots; i++) begin
            alloc_s[i] = accept_s & free_s[i] & ~taken;
            taken      = taken | free_s[i];
        end
    end

    // Round-robin search over READY slots starting at rr_r.
    always_comb begin
        int              cand;
        logic [IdxW-1:0] cand_idx;
        cand         = 0;
        cand_idx     = '0;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int off = 0; off < NumSlots; off++) begin
            cand = int'(rr_r) + off;
            if (cand >= NumSlots) begin
                cand = cand - NumSlots;
            end else begin
                cand = cand;
            end
            cand_idx     = IdxW'(cand);
            pick_idx_s   = (ready_s[cand_idx] & ~pick_valid_s) ? cand_idx : pick_idx_s;
            pick_valid_s = pick_valid_s | ready_s[cand_idx];
        end
    end

    // A locked grant overrides the arbiter so a stalled response cannot change.
    assign sel_valid_s = lock_valid_r | pick_valid_s;
    assign sel_idx_s   = lock_valid_r ? lock_idx_r : pick_idx_s;
    assign handshake_s = sel_valid_s & resp_ready_i;
    assign rr_next_s   = (sel_idx_s == IdxW'(NumSlots - 1)) ? '0 : sel_idx_s + IdxW'(1);

    assign resp_valid_o = sel_valid_s;
    assign resp_id_o    = sel_valid_s ? slot_id_s[sel_idx_s]   : '0;
    assign resp_data_o  = sel_valid_s ? slot_data_s[sel_idx_s] : '0;

    // Release strobe for the slot whose response was consumed this cycle.
    always_comb begin
        rel_s = '0;
        for (int i = 0; i < NumSlots; i++) begin
            rel_s[i] = handshake_s & (sel_idx_s == IdxW'(i));
        end
    end

    // Round-robin pointer and grant lock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_r         <= '0;
            lock_valid_r <= 1'b0;
            lock_idx_r   <= '0;
        end else if (handshake_s) begin
            rr_r         <= rr_next_s;
            lock_valid_r <= 1'b0;
            lock_idx_r   <= '0;
        end else if (sel_valid_s) begin
            rr_r         <= rr_r;
            lock_valid_r <= 1'b1;
            lock_idx_r   <= sel_idx_s;
        end else begin
            rr_r         <= rr_r;
            lock_valid_r <= 1'b0;
            lock_idx_r   <= lock_idx_r;
        end
    end

    tagged_ooo_responder_chk #(
        .DataWidth (DataWidth),
        .NumSlots  (NumSlots),
        .IdWidth   (IdWidth)
    ) u_chk (
        .clk        (clk_i),
        .rst        (rst_i),
        .req_valid  (req_valid_i),
        .req_ready  (req_ready_o),
        .req_id     (req_id_i),
        .occupied   (~free_s),
        .ids_flat   (ids_flat_s),
        .resp_valid (resp_valid_o),
        .resp_ready (resp_ready_i),
        .resp_id    (resp_id_o),
        .resp_data  (resp_data_o)
    );

endmodule

// File: tb/tb_tagged_ooo_responder.sv
// Directed bench for tagged_ooo_responder (default parameters).
module tb_tagged_ooo_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [31:0] req_data;
    logic [3:0]  req_lat;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_id;
    logic [31:0] resp_data;
    logic        busy;

    int n_asserts = 0;
    int n_fails   = 0;

    tagged_ooo_responder dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_id_i     (req_id),
        .req_data_i   (req_data),
        .req_lat_i    (req_lat),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the middle of the next cycle.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] id, input logic [31:0] data, input logic [3:0] lat);
        req_valid = 1'b1;
        req_id    = id;
        req_data  = data;
        req_lat   = lat;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_id    = 4'd0;
        req_data  = 32'd0;
        req_lat   = 4'd0;
    endtask

    initial begin
        rst        = 1'b1;
        resp_ready = 1'b1;
        idle_req();

        // ---------------- reset state
        tick();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        tick();
        rst = 1'b0;
        chk("rst_req_ready",  32'(req_ready),  32'd1);

        // ---------------- single request, zero latency
        tick();
        drive_req(4'd3, 32'hA5A5_0001, 4'd0);
        chk("single_ready_t",  32'(req_ready),  32'd1);
        chk("single_nocomb_t", 32'(resp_valid), 32'd0);
        tick();
        idle_req();
        chk("single_valid_t1", 32'(resp_valid), 32'd1);
        chk("single_id_t1",    32'(resp_id),    32'd3);
        chk("single_data_t1",  resp_data,       32'hA5A5_0001);
        chk("single_busy_t1",  32'(busy),       32'd1);
        tick();
        chk("single_valid_t2", 32'(resp_valid), 32'd0);
        chk("single_busy_t2",  32'(busy),       32'd0);

        // ---------------- reordering: id1 lat5 then id2 lat0
        tick();                                   // cycle 0
        drive_req(4'd1, 32'h1111_0001, 4'd5);
        tick();                                   // cycle 1
        drive_req(4'd2, 32'h2222_0002, 4'd0);
        chk("reord_valid_c1", 32'(resp_valid), 32'd0);
        tick();                                   // cycle 2
        idle_req();
        chk("reord_valid_c2", 32'(resp_valid), 32'd1);
        chk("reord_id_c2",    32'(resp_id),    32'd2);
        chk("reord_data_c2",  resp_data,       32'h2222_0002);
        for (int c = 3; c <= 5; c++) begin
            tick();
            chk("reord_gap_valid", 32'(resp_valid), 32'd0);
        end
        tick();                                   // cycle 6
        chk("reord_valid_c6", 32'(resp_valid), 32'd1);
        chk("reord_id_c6",    32'(resp_id),    32'd1);
        chk("reord_data_c6",  resp_data,       32'h1111_0001);
        tick();                                   // cycle 7
        chk("reord_valid_c7", 32'(resp_valid), 32'd0);
        chk("reord_busy_c7",  32'(busy),       32'd0);

        // ---------------- full: four lat15 requests, no response consumption
        resp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            drive_req(4'(4 + c), 32'hF000_0000 + 32'(c), 4'd15);
            chk("full_ready_fill", 32'(req_ready), 32'd1);
        end
        tick();                                   // cycle 4
        idle_req();
        chk("full_ready_c4", 32'(req_ready), 32'd0);
        chk("full_busy_c4",  32'(busy),      32'd1);
        for (int c = 5; c <= 15; c++) begin
            tick();
            chk("full_wait_valid", 32'(resp_valid), 32'd0);
        end
        tick();                                   // cycle 16: slot 0 ready
        chk("full_valid_c16", 32'(resp_valid), 32'd1);
        chk("full_id_c16",    32'(resp_id),    32'd4);
        for (int c = 17; c <= 19; c++) begin
            tick();
            chk("full_locked_id", 32'(resp_id), 32'd4);
        end
        tick();                                   // cycle 20: release slot 0
        resp_ready = 1'b1;
        chk("full_ready_hs_cycle", 32'(req_ready), 32'd0);
        chk("full_hs_id",          32'(resp_id),   32'd4);
        chk("full_hs_data",        resp_data,      32'hF000_0000);
        tick();                                   // cycle 21
        chk("full_ready_after_hs", 32'(req_ready), 32'd1);
        chk("full_drain_id5",      32'(resp_id),   32'd5);
        tick();
        chk("full_drain_id6",      32'(resp_id),   32'd6);
        tick();
        chk("full_drain_id7",      32'(resp_id),   32'd7);
        tick();
        chk("full_drain_valid",    32'(resp_valid), 32'd0);
        chk("full_drain_busy",     32'(busy),       32'd0);

        // ---------------- backpressure stability (rr = 0)
        resp_ready = 1'b0;
        tick();                                   // cycle 0
        drive_req(4'd8, 32'hD000_0008, 4'd0);
        tick();                                   // cycle 1
        drive_req(4'd9, 32'hD000_0009, 4'd3);
        chk("bp_valid_c1", 32'(resp_valid), 32'd1);
        chk("bp_id_c1",    32'(resp_id),    32'd8);
        tick();                                   // cycle 2
        drive_req(4'd10, 32'hD000_000A, 4'd0);
        chk("bp_id_c2",    32'(resp_id),    32'd8);
        tick();                                   // cycle 3
        idle_req();
        for (int c = 3; c <= 6; c++) begin
            chk("bp_stable_id",   32'(resp_id),    32'd8);
            chk("bp_stable_data", resp_data,       32'hD000_0008);
            chk("bp_stable_vld",  32'(resp_valid), 32'd1);
            if (c < 6) begin
                tick();
            end else begin
                resp_ready = 1'b1;
            end
        end
        tick();                                   // cycle 7
        chk("bp_next_id9",  32'(resp_id),   32'd9);
        chk("bp_next_data", resp_data,      32'hD000_0009);
        tick();                                   // cycle 8
        chk("bp_next_id10", 32'(resp_id),   32'd10);
        tick();                                   // cycle 9
        chk("bp_end_valid", 32'(resp_valid), 32'd0);

        // ---------------- wrap/fairness: grant order 0,1,2,3,0
        resp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            drive_req(4'(c), 32'hC000_0000 + 32'(c), 4'd0);
        end
        tick();                                   // cycle 4: all READY
        idle_req();
        resp_ready = 1'b1;
        chk("wrap_g0_id", 32'(resp_id), 32'd0);
        tick();                                   // cycle 5: refill slot 0
        drive_req(4'd12, 32'hC000_000C, 4'd0);
        chk("wrap_g1_id", 32'(resp_id), 32'd1);
        tick();
        idle_req();
        chk("wrap_g2_id", 32'(resp_id), 32'd2);
        tick();
        chk("wrap_g3_id", 32'(resp_id), 32'd3);
        tick();
        chk("wrap_g4_id",   32'(resp_id), 32'd12);
        chk("wrap_g4_data", resp_data,    32'hC000_000C);
        tick();
        chk("wrap_end_valid", 32'(resp_valid), 32'd0);
        chk("wrap_end_busy",  32'(busy),       32'd0);

        // ---------------- reset mid-operation with three slots waiting
        for (int c = 0; c < 3; c++) begin
            tick();
            drive_req(4'(1 + c), 32'hB000_0000 + 32'(c), 4'd10);
        end
        tick();
        idle_req();
        chk("mrst_busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid_async", 32'(resp_valid), 32'd0);
        chk("mrst_busy_async",  32'(busy),       32'd0);
        tick();
        rst = 1'b0;
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 16; c++) begin
            tick();
            chk("mrst_no_stale", 32'(resp_valid), 32'd0);
        end
        chk("mrst_busy_end", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
